// File: rtl/de1_pkg.sv
// Board-level constants for the DE1 input conditioning logic.
package de1_pkg;

  localparam int unsigned CLK_HZ        = 50_000_000;
  localparam int unsigned DEBOUNCE_MS   = 20;
  localparam int unsigned CYCLES_PER_MS = CLK_HZ / 1000;

  // Converts a debounce interval in milliseconds to CLOCK_50 cycles.
  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return ms * CYCLES_PER_MS;
  endfunction

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS);

endpackage : de1_pkg

// File: rtl/debounce_bit.sv
// Single-bit synchroniser, stability counter and edge-pulse generator.
// The output is normalised to active-high.
module debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pressed,
  output logic released
);

  localparam int unsigned CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic        IDLE_RAW = ACTIVE_LOW;

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt_q;
  logic             norm_c;

  assign norm_c = sync_q2 ^ ACTIVE_LOW;

  // Two-flop synchroniser; only sync_q1 ever samples the raw pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= IDLE_RAW;
      sync_q2 <= IDLE_RAW;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  // Any return to the current level restarts the stability interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      level    <= 1'b0;
      pressed  <= 1'b0;
      released <= 1'b0;
    end else begin
      pressed  <= 1'b0;
      released <= 1'b0;
      if (norm_c == level) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt_q    <= '0;
        level    <= norm_c;
        pressed  <= norm_c;
        released <= ~norm_c;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule : debounce_bit

// File: rtl/input_debouncer.sv
// Debounces a bank of DE1 buttons or switches into active-high levels
// with one-cycle press/release pulses; bits are fully independent.
module input_debouncer
  import de1_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic [WIDTH-1:0] RAW,
  output logic [WIDTH-1:0] LEVEL,
  output logic [WIDTH-1:0] PRESSED,
  output logic [WIDTH-1:0] RELEASED
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_bit (
      .clk      (CLOCK_50),
      .rst      (RESET),
      .raw      (RAW[i]),
      .level    (LEVEL[i]),
      .pressed  (PRESSED[i]),
      .released (RELEASED[i])
    );
  end

endmodule : input_debouncer

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer: directed scenarios plus a
// randomized run compared against a sliding-window reference model.
module tb_input_debouncer;

  localparam int unsigned W  = 4;
  localparam int unsigned D  = 8;
  localparam int unsigned WH = 10;

  logic          clk;
  logic          rst;
  logic [W-1:0]  raw;
  logic [W-1:0]  level, pressed, released;
  logic          rst_hi;
  logic [WH-1:0] raw_hi;
  logic [WH-1:0] level_hi, pressed_hi, released_hi;

  int total = 0;
  int bad   = 0;

  input_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1)) u_dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .RAW      (raw),
    .LEVEL    (level),
    .PRESSED  (pressed),
    .RELEASED (released)
  );

  input_debouncer #(.WIDTH(WH), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b0)) u_dut_hi (
    .CLOCK_50 (clk),
    .RESET    (rst_hi),
    .RAW      (raw_hi),
    .LEVEL    (level_hi),
    .PRESSED  (pressed_hi),
    .RELEASED (released_hi)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference model: the pin reaches the decision logic two edges late;
  // a level flips when the last D normalised samples all disagree with it.
  logic [W-1:0] m_s1, m_s2, m_lvl, m_pr, m_rl;
  logic [D-1:0] m_hist [W];

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_s1 = '1;
        m_s2 = '1;
        m_lvl = '0;
        m_pr = '0;
        m_rl = '0;
        for (int b = 0; b < W; b++) m_hist[b] = '0;
      end else begin
        m_pr = '0;
        m_rl = '0;
        for (int b = 0; b < W; b++) begin
          m_hist[b] = {m_hist[b][D-2:0], ~m_s2[b]};
          if (m_hist[b] == {D{~m_lvl[b]}}) begin
            m_lvl[b] = ~m_lvl[b];
            if (m_lvl[b]) m_pr[b] = 1'b1;
            else          m_rl[b] = 1'b1;
          end
        end
        m_s2 = m_s1;
        m_s1 = raw;
      end
    end
  end

  task automatic test_reset();
    raw    = '1;
    raw_hi = '0;
    rst    = 1'b1;
    rst_hi = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (level !== '0 || pressed !== '0 || released !== '0) begin
        bad++;
        $display("FAIL reset_hold: level=%b pressed=%b released=%b want 0", level, pressed, released);
      end
    end
    rst    = 1'b0;
    rst_hi = 1'b0;
    repeat (20) begin
      @(negedge clk);
      total++;
      if (level !== '0 || pressed !== '0 || released !== '0) begin
        bad++;
        $display("FAIL reset_idle: level=%b pressed=%b released=%b want 0", level, pressed, released);
      end
    end
  endtask

  task automatic test_clean_press();
    raw[0] = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      @(negedge clk);
      total++;
      if (level !== ((e >= 10) ? 4'b0001 : 4'b0000) ||
          pressed !== ((e == 10) ? 4'b0001 : 4'b0000) || released !== 4'b0000) begin
        bad++;
        $display("FAIL clean_press e=%0d: level=%b pressed=%b released=%b", e, level, pressed, released);
      end
    end
  endtask

  task automatic test_bounce();
    logic [2:0] pattern [2];
    pattern[0] = 3'd5;
    pattern[1] = 3'd2;
    for (int ph = 0; ph < 2; ph++) begin
      raw[1] = (ph == 0) ? 1'b0 : 1'b1;
      for (int c = 0; c < int'(pattern[ph]); c++) begin
        @(negedge clk);
        total++;
        if (level !== 4'b0001 || pressed !== '0 || released !== '0) begin
          bad++;
          $display("FAIL bounce_hold: level=%b pressed=%b released=%b want 0001/0/0", level, pressed, released);
        end
      end
    end
    raw[1] = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      @(negedge clk);
      total++;
      if (level !== ((e >= 10) ? 4'b0011 : 4'b0001) ||
          pressed !== ((e == 10) ? 4'b0010 : 4'b0000) || released !== '0) begin
        bad++;
        $display("FAIL bounce_settle e=%0d: level=%b pressed=%b released=%b", e, level, pressed, released);
      end
    end
  endtask

  task automatic test_release_simul();
    raw[0] = 1'b1;
    raw[2] = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      @(negedge clk);
      total++;
      if (level !== ((e >= 10) ? 4'b0110 : 4'b0011) ||
          pressed !== ((e == 10) ? 4'b0100 : 4'b0000) ||
          released !== ((e == 10) ? 4'b0001 : 4'b0000)) begin
        bad++;
        $display("FAIL release_simul e=%0d: level=%b pressed=%b released=%b", e, level, pressed, released);
      end
    end
  endtask

  task automatic test_reset_mid();
    raw[3] = 1'b0;
    repeat (7) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    total++;
    if (level !== '0 || released !== '0 || pressed !== '0) begin
      bad++;
      $display("FAIL reset_mid_clear: level=%b pressed=%b released=%b want 0", level, pressed, released);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      @(negedge clk);
      total++;
      if (level !== ((e >= 10) ? 4'b1110 : 4'b0000) ||
          pressed !== ((e == 10) ? 4'b1110 : 4'b0000) || released !== '0) begin
        bad++;
        $display("FAIL reset_mid e=%0d: level=%b pressed=%b released=%b", e, level, pressed, released);
      end
    end
  endtask

  task automatic test_active_high();
    raw_hi = 10'h3FF;
    for (int e = 1; e <= 11; e++) begin
      @(negedge clk);
      total++;
      if (level_hi !== ((e >= 10) ? 10'h3FF : 10'h000) ||
          pressed_hi !== ((e == 10) ? 10'h3FF : 10'h000) || released_hi !== 10'h000) begin
        bad++;
        $display("FAIL active_high e=%0d: level=%h pressed=%h released=%h", e, level_hi, pressed_hi, released_hi);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      total++;
      if (level !== m_lvl || pressed !== m_pr || released !== m_rl) begin
        bad++;
        $display("FAIL random c=%0d: level=%b/%b pressed=%b/%b released=%b/%b (got/want)",
                 c, level, m_lvl, pressed, m_pr, released, m_rl);
      end
      total++;
      if ((pressed & released) !== '0) begin
        bad++;
        $display("FAIL random_overlap c=%0d: pressed=%b released=%b", c, pressed, released);
      end
      for (int b = 0; b < W; b++) begin
        if ($urandom_range(0, 11) == 0) raw[b] = ~raw[b];
      end
      if (c == 1500) begin
        #3 rst = 1'b1;
        #5 rst = 1'b0;
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    rst_hi = 1'b1;
    raw    = '1;
    raw_hi = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_simul();
    test_reset_mid();
    test_active_high();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_input_debouncer

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Conditioning stage between the DE1 board pins (BUTTONS active-low, SW active-high) and the top-level logic that drives LEDR/LEDG.
- Per bit: synchronises the raw pin to CLOCK_50, debounces it with a stability counter, and normalises it to active-high.
- Also emits single-cycle press and release pulses for downstream counters and FSMs.
- One instance is used for BUTTONS and one for SW.

Parameters:
- WIDTH, 4, number of independent input bits.
- DEBOUNCE_CYCLES, 1000000, number of consecutive stable clocks required to accept a new level (20 ms at 50 MHz). Must be >= 2.
- ACTIVE_LOW, 1, 1 = raw pin is asserted when 0 (BUTTONS); 0 = asserted when 1 (SW).

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- RESET  input  1  asynchronous reset, active-high.
- RAW  input  WIDTH  asynchronous pin inputs, polarity per ACTIVE_LOW.
- LEVEL  output  WIDTH  debounced level, active-high (1 = pressed/on).
- PRESSED  output  WIDTH  one-cycle pulse when LEVEL bit goes 0->1.
- RELEASED  output  WIDTH  one-cycle pulse when LEVEL bit goes 1->0.

Behaviour:
- Clock and reset: one clock, CLOCK_50. Reset is asynchronous and active-high on RESET. All state clears immediately on RESET assertion, regardless of the clock.
- Reset values:
  - LEVEL = 0, PRESSED = 0, RELEASED = 0.
  - Both synchroniser flops hold the inactive raw value: all-ones if ACTIVE_LOW = 1, else all-zeros.
  - Counters = 0.
- Per-bit datapath, all bits fully independent:
  - 2-flop synchroniser produces s. s is inverted when ACTIVE_LOW = 1, giving a normalised signal n.
  - Counter width is $clog2(DEBOUNCE_CYCLES); it saturates nowhere and is never allowed to wrap.
- Each rising edge, per bit:
  - If n == LEVEL: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: LEVEL <= n, counter <= 0, and the edge pulse is asserted.
  - Else: counter <= counter + 1.
- Pulses:
  - PRESSED and RELEASED are registered and assert in the same cycle that LEVEL changes.
  - Each pulse is high for exactly one cycle.
  - PRESSED and RELEASED are never high together on the same bit.
- Latency: counting the first edge that samples a new raw value as edge 1, LEVEL and the pulse update on edge DEBOUNCE_CYCLES+2, provided the raw value stays stable throughout.
- Glitch rejection: any return of n to LEVEL before the count completes clears the counter, and there is no output change. A bounce train therefore restarts the full interval on every bounce.
- Simultaneous events: several bits may change or pulse in the same cycle. There is no interaction between bits.
- Reset mid-count: the partial count is discarded. LEVEL returns to 0 with no RELEASED pulse.
- Input asserted across reset release: it is treated as a fresh assertion. LEVEL rises, and PRESSED pulses once, after the full latency.
- Metastability: only the first synchroniser flop may sample RAW. No combinational path exists from RAW to any output.

Decomposition:
- Shared package de1_pkg:
  - CLK_HZ = 50000000.
  - DEBOUNCE_MS default = 20.
  - Helper constant for the cycles-from-ms computation.
- Sub-module debounce_bit: single-bit synchroniser + counter + edge pulse, with DEBOUNCE_CYCLES and ACTIVE_LOW parameters.
- input_debouncer instantiates WIDTH copies of debounce_bit through a generate loop.

Test Plan (DEBOUNCE_CYCLES = 8, ACTIVE_LOW = 1, WIDTH = 4 unless stated):
1. Reset value: hold RAW = 4'b1111 and pulse RESET → LEVEL = 0, PRESSED = 0, RELEASED = 0 during reset and for 20 cycles after release.
2. Clean press: drive RAW[0] 1->0 and hold → LEVEL[0] = 1 and PRESSED[0] = 1 on edge 10 (edge 1 = first sample); PRESSED[0] = 0 on edge 11; other bits stay 0.
3. Bounce rejection: toggle RAW[1] low for 5 cycles, high for 2, then hold low → no output change during the bounce; LEVEL[1] rises 10 edges after the final falling transition, with exactly one PRESSED pulse.
4. Release and simultaneity: with LEVEL = 4'b0011 debounced, release RAW[0] and press RAW[2] on the same edge → on edge 10, LEVEL = 4'b0110, RELEASED = 4'b0001, PRESSED = 4'b0100.
5. Reset mid-count: press RAW[3], assert RESET at count 5, release RESET with RAW[3] still low → LEVEL[3] = 0 with no RELEASED pulse; LEVEL[3] = 1 and PRESSED[3] = 1 occur 10 edges after reset release.
6. Active-high variant: ACTIVE_LOW = 0, WIDTH = 10, RAW 10'h000->10'h3FF → LEVEL = 10'h3FF and PRESSED = 10'h3FF for one cycle on edge 10.
